// File: rtl/line_fill_memory.sv
// ---------------------------------------------------------------------------
// line_fill_memory
//
// Backing main-memory responder for the memory side of the cache controller.
// It serves whole-line fills (reads) and dirty-line writebacks (writes) one
// byte per beat. Fills have a fixed access latency. The store is a byte
// array that powers up holding its own index (mem[i] = i[7:0]).
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset (store contents survive)
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE, not in reset)
//   req_write  in   1 = writeback, 0 = line fill (sampled at accept)
//   req_addr   in   any byte address inside the line (sampled at accept)
//   wr_valid   in   writeback byte present this cycle
//   wr_data    in   writeback byte
//   rd_valid   out  fill beat valid
//   rd_data    out  fill byte
//   rd_last    out  final fill beat
//   wr_done    out  one-cycle pulse once the whole line has been stored
//   busy       out  a request is in progress
// ---------------------------------------------------------------------------
module line_fill_memory #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 8,
    parameter int LINE_BYTES   = 16,
    parameter int MEM_AW       = 12,
    parameter int READ_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              wr_done,
    output logic              busy
);

    localparam int OFF_W     = $clog2(LINE_BYTES);
    localparam int BASE_W    = MEM_AW - OFF_W;
    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam int LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [OFF_W-1:0] ZERO_OFF  = '0;
    localparam logic [OFF_W-1:0] ONE_OFF   = OFF_W'(1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_BYTES - 1);
    localparam logic [LAT_W-1:0] LAT_END   = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_DONE
    } state_t;

    typedef logic [DATA_W-1:0] mem_t [MEM_DEPTH];

    // Power-up image of the store: every byte holds the low bits of its index.
    function automatic mem_t initMem();
        mem_t m;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            m[i] = DATA_W'(i);
        end
        return m;
    endfunction

    mem_t r_mem = initMem();

    state_t             r_state;
    logic [BASE_W-1:0]  r_base;
    logic [OFF_W-1:0]   r_beat;
    logic [LAT_W-1:0]   r_lat;
    logic               r_reqReady;
    logic               r_rdValid;
    logic [DATA_W-1:0]  r_rdData;
    logic               r_rdLast;
    logic               r_wrDone;
    logic               r_busy;

    logic               w_accept;
    logic [BASE_W-1:0]  w_reqBase;
    logic               w_memWe;
    logic               w_unusedAddrBits;

    // Only the line index inside the backing store matters; the byte offset
    // and everything above MEM_AW are dropped, so high addresses alias.
    assign w_reqBase        = req_addr[MEM_AW-1:OFF_W];
    assign w_unusedAddrBits = ^{req_addr[ADDR_W-1:MEM_AW], req_addr[OFF_W-1:0]};
    assign w_accept         = req_valid && r_reqReady;
    assign w_memWe          = (r_state == WR_BURST) && wr_valid;

    // Byte store write port. Writes only happen while a writeback burst is
    // open; a reset edge abandons the burst and stores nothing on that edge.
    always_ff @(posedge clk) begin
        if (!reset && w_memWe) begin
            r_mem[{r_base, r_beat}] <= wr_data;
        end
    end

    // Request sequencer. Every output is a register updated alongside the
    // state, so rd_valid/rd_last line up exactly with the byte in rd_data
    // and req_ready/busy change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_beat     <= '0;
            r_lat      <= '0;
            r_reqReady <= 1'b0;
            r_rdValid  <= 1'b0;
            r_rdData   <= '0;
            r_rdLast   <= 1'b0;
            r_wrDone   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Ready rises here on the first cycle out of reset.
                    r_reqReady <= 1'b1;
                    r_rdValid  <= 1'b0;
                    r_rdLast   <= 1'b0;
                    r_wrDone   <= 1'b0;
                    if (w_accept) begin
                        r_base     <= w_reqBase;
                        r_beat     <= '0;
                        r_lat      <= '0;
                        r_reqReady <= 1'b0;
                        r_busy     <= 1'b1;
                        if (req_write) begin
                            r_state <= WR_BURST;
                        end else if (READ_LATENCY == 1) begin
                            // Single-cycle latency: beat 0 leaves on the accept edge.
                            r_state   <= RD_BURST;
                            r_rdValid <= 1'b1;
                            r_rdData  <= r_mem[{w_reqBase, ZERO_OFF}];
                            r_beat    <= ONE_OFF;
                        end else begin
                            r_state <= RD_WAIT;
                        end
                    end
                end

                RD_WAIT: begin
                    // r_lat is 0 on the first edge after accept, so reaching
                    // READ_LATENCY-1 puts beat 0 out READ_LATENCY edges after accept.
                    if (r_lat == LAT_END) begin
                        r_state   <= RD_BURST;
                        r_rdValid <= 1'b1;
                        r_rdData  <= r_mem[{r_base, ZERO_OFF}];
                        r_rdLast  <= 1'b0;
                        r_beat    <= ONE_OFF;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end

                RD_BURST: begin
                    // r_beat is the index of the next beat to present; once the
                    // last beat has been on the bus for its cycle we drop back.
                    if (r_rdLast) begin
                        r_state    <= IDLE;
                        r_rdValid  <= 1'b0;
                        r_rdLast   <= 1'b0;
                        r_reqReady <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_rdData <= r_mem[{r_base, r_beat}];
                        r_rdLast <= (r_beat == LAST_BEAT);
                        r_beat   <= r_beat + 1'b1;
                    end
                end

                WR_BURST: begin
                    if (wr_valid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == LAST_BEAT) begin
                            r_state  <= WR_DONE;
                            r_wrDone <= 1'b1;
                        end
                    end
                end

                WR_DONE: begin
                    r_wrDone   <= 1'b0;
                    r_state    <= IDLE;
                    r_reqReady <= 1'b1;
                    r_busy     <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_reqReady;
    assign rd_valid  = r_rdValid;
    assign rd_data   = r_rdData;
    assign rd_last   = r_rdLast;
    assign wr_done   = r_wrDone;
    assign busy      = r_busy;

endmodule

// File: tb/tb_line_fill_memory.sv
// ---------------------------------------------------------------------------
// tb_line_fill_memory
//
// Self-checking bench for line_fill_memory. A plain byte array mirrors the
// backing store; each transaction task works out, cycle by cycle after the
// accept edge, what the handshake and data outputs must show and compares.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_line_fill_memory;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 8;
    localparam int LINE         = 16;
    localparam int MEM_AW       = 12;
    localparam int MEM_DEPTH    = 1 << MEM_AW;
    localparam int LAT          = 4;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              wr_done;
    logic              busy;

    logic [7:0] refMem [MEM_DEPTH];
    logic [7:0] wbData [LINE];

    int testsRun    = 0;
    int testsFailed = 0;

    line_fill_memory #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .LINE_BYTES   (LINE),
        .MEM_AW       (MEM_AW),
        .READ_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .wr_done   (wr_done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a stuck run still ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // First byte index of the line an address maps to, from address arithmetic.
    function automatic int lineBase(input logic [31:0] addr);
        return int'(addr % MEM_DEPTH) / LINE * LINE;
    endfunction

    // Hold reset for one edge, check reset values, release and check ready.
    task automatic pulseReset(input string tag);
        reset     = 1'b1;
        req_valid = 1'b0;
        wr_valid  = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_rst_ready"},   32'(req_ready), 32'd0);
        checkOutput({tag, "_rst_rdValid"}, 32'(rd_valid),  32'd0);
        checkOutput({tag, "_rst_rdLast"},  32'(rd_last),   32'd0);
        checkOutput({tag, "_rst_wrDone"},  32'(wr_done),   32'd0);
        checkOutput({tag, "_rst_busy"},    32'(busy),      32'd0);
        checkOutput({tag, "_rst_rdData"},  32'(rd_data),   32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_post_ready"},  32'(req_ready), 32'd1);
        checkOutput({tag, "_post_busy"},   32'(busy),      32'd0);
    endtask

    // Line fill. abortBeat >= 0 asserts reset while that beat is on the bus.
    // holdValid leaves req_valid high (as a write) for the next transaction.
    task automatic doFill(input logic [31:0] addr, input int abortBeat,
                          input bit holdValid);
        int         base;
        bit         expV;
        logic [11:0] idx;
        base      = lineBase(addr);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        checkOutput("fill_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        if (holdValid) begin
            req_write = 1'b1;
            req_addr  = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        for (int c = 0; c <= LAT + LINE; c++) begin
            expV = (c >= LAT) && (c < LAT + LINE);
            checkOutput("fill_rdValid", 32'(rd_valid),  32'(expV));
            checkOutput("fill_rdLast",  32'(rd_last),   32'(c == LAT + LINE - 1));
            checkOutput("fill_ready",   32'(req_ready), 32'(c == LAT + LINE));
            checkOutput("fill_busy",    32'(busy),      32'(c < LAT + LINE));
            checkOutput("fill_wrDone",  32'(wr_done),   32'd0);
            if (expV) begin
                idx = 12'(base + c - LAT);
                checkOutput("fill_rdData", 32'(rd_data), 32'(refMem[idx]));
            end
            if (c == LAT + LINE) break;
            if (abortBeat >= 0 && c == LAT + abortBeat) begin
                pulseReset("fillAbort");
                return;
            end
            // Writeback beats during a fill must be ignored.
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = 8'($urandom);
            @(negedge clk);
        end
        wr_valid = 1'b0;
    endtask

    // Writeback of wbData. gapMode 0: no gaps, 1: 1,0,1,0..., 2: random.
    // abortAfter >= 0 asserts reset once that many bytes are stored.
    task automatic doWrite(input logic [31:0] addr, input int gapMode,
                           input int abortAfter, input bit holdValid);
        int          base;
        int          k;
        int          budget;
        bit          wrv;
        logic [11:0] idx;
        base      = lineBase(addr);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        checkOutput("wb_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        if (holdValid) begin
            req_write = 1'b0;
            req_addr  = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        k      = 0;
        budget = 0;
        while (k < LINE) begin
            if (abortAfter >= 0 && k == abortAfter) begin
                pulseReset("wbAbort");
                return;
            end
            if (budget >= 300) begin
                checkOutput("wb_timeout", 32'(k), 32'(LINE));
                pulseReset("wbTimeout");
                return;
            end
            case (gapMode)
                0:       wrv = 1'b1;
                1:       wrv = (budget % 2 == 0);
                default: wrv = 1'($urandom_range(0, 1));
            endcase
            wr_valid = wrv;
            wr_data  = wrv ? wbData[k] : 8'($urandom);
            @(negedge clk);
            budget++;
            if (wrv) begin
                idx         = 12'(base + k);
                refMem[idx] = wbData[k];
                k++;
            end
            checkOutput("wb_wrDone", 32'(wr_done),   32'(k == LINE));
            checkOutput("wb_busy",   32'(busy),      32'd1);
            checkOutput("wb_ready",  32'(req_ready), 32'd0);
        end
        // A stray beat while the done pulse is out must not be stored.
        wr_valid = 1'b1;
        wr_data  = 8'($urandom);
        @(negedge clk);
        wr_valid = 1'b0;
        checkOutput("wb_doneEnd", 32'(wr_done),   32'd0);
        checkOutput("wb_idleBusy", 32'(busy),     32'd0);
        checkOutput("wb_idleReady", 32'(req_ready), 32'd1);
        checkOutput("wb_rdValid", 32'(rd_valid),  32'd0);
    endtask

    task automatic applyStimulus();
        logic [31:0] addr;
        int          abortAt;
        bit          isWrite;

        // Directed: fill of an aliased address from the power-up image.
        doFill(32'h0200_1f81, -1, 1'b0);

        // Back-to-back writeback then readback of the same line.
        for (int i = 0; i < LINE; i++) wbData[i] = 8'(8'hA0 + i);
        doWrite(32'h0200_1f71, 0, -1, 1'b0);
        doFill(32'h0200_1f7c, -1, 1'b0);

        // Writeback with every other cycle empty.
        for (int i = 0; i < LINE; i++) wbData[i] = 8'($urandom);
        doWrite(32'h0200_1f41, 1, -1, 1'b0);
        doFill(32'h0000_0f4f, -1, 1'b0);

        // Reset during fill beat 5, then full refill.
        doFill(32'h0200_1f51, 5, 1'b0);
        doFill(32'h0200_1f51, -1, 1'b0);

        // Reset after three writeback bytes; the rest keeps old contents.
        wbData[0] = 8'h11;
        wbData[1] = 8'h22;
        wbData[2] = 8'h33;
        doWrite(32'h0200_1f40, 0, 3, 1'b0);
        doFill(32'h0200_1f40, -1, 1'b0);

        // req_valid held high throughout with alternating direction.
        for (int t = 0; t < 6; t++) begin
            addr = $urandom | 32'h0000_0FC0;
            if (t % 2 == 0) begin
                for (int i = 0; i < LINE; i++) wbData[i] = 8'($urandom);
                doWrite(addr, 2, -1, 1'b1);
            end else begin
                doFill(addr, -1, t != 5);
            end
        end

        // Random traffic over four aliased lines with occasional resets.
        for (int t = 0; t < 24; t++) begin
            addr    = $urandom | 32'h0000_0FC0;
            isWrite = 1'($urandom_range(0, 1));
            abortAt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, LINE - 1) : -1;
            if (isWrite) begin
                for (int i = 0; i < LINE; i++) wbData[i] = 8'($urandom);
                doWrite(addr, 2, abortAt, 1'b0);
            end else begin
                doFill(addr, abortAt, 1'b0);
            end
        end

        // Final readback of every line the random traffic touched.
        for (int l = 0; l < 4; l++) begin
            doFill(32'h0000_0FC0 + 32'(l * LINE), -1, 1'b0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        for (int i = 0; i < MEM_DEPTH; i++) refMem[i] = 8'(i);
        @(negedge clk);
        pulseReset("init");
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/line_fill_memory.md
Name: line_fill_memory

Overview:
- Backing main-memory responder on the memory side of the cache controller.
- On a miss, the controller acts as initiator: it requests a whole line fill (read) or a dirty-line writeback (write).
- This block serves those requests: fixed access latency, byte-per-beat line bursts, simulation-oriented byte-array store.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 8, beat/byte width
- LINE_BYTES, 16, bytes per cache line (power of 2); offset bits OFF_W = log2(LINE_BYTES)
- MEM_AW, 12, backing-store index width (2^MEM_AW bytes; upper address bits ignored/aliased)
- READ_LATENCY, 4, cycles from request accept to first read beat (>=1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept request
- req_write  in  1  1 = writeback, 0 = line fill
- req_addr  in  ADDR_W  any byte address in the line; low OFF_W bits ignored
- wr_valid  in  1  writeback data beat present
- wr_data  in  DATA_W  writeback byte
- rd_valid  out  1  fill data beat valid
- rd_data  out  DATA_W  fill byte
- rd_last  out  1  final fill beat
- wr_done  out  1  one-cycle pulse after last writeback byte stored
- busy  out  1  state != IDLE

Behaviour:
- Store: byte array of 2^MEM_AW entries, initialised at time zero to mem[i] = i[7:0]. Reset does not alter contents.
- Index of beat k: {req_addr[MEM_AW-1:OFF_W], k[OFF_W-1:0]}, with the line base latched at accept.
- Handshake: the request is accepted on a rising edge with req_valid && req_ready. req_ready = 1 only in IDLE and not in reset. req_addr/req_write are sampled only at accept.
- States:
  - IDLE: on accept, go to RD_WAIT (req_write=0) or WR_BURST (req_write=1); beat counter cleared.
  - RD_WAIT: latency counter counts READ_LATENCY-1 cycles, then RD_BURST. The first rd_valid is high exactly READ_LATENCY cycles after the accept edge.
  - RD_BURST: rd_valid=1 for LINE_BYTES consecutive cycles; rd_data = byte at beat k, k = 0..LINE_BYTES-1 in ascending order. rd_last=1 on beat LINE_BYTES-1. No backpressure: the initiator must take every beat. After the last beat, return to IDLE.
  - WR_BURST: each cycle with wr_valid=1 stores wr_data at beat k and increments k. Gaps (wr_valid=0) are allowed and hold k. wr_valid in any other state is ignored. After beat LINE_BYTES-1 is stored, go to WR_DONE.
  - WR_DONE: wr_done=1 for one cycle, then IDLE. A readback of the same line is accepted no earlier than the cycle after wr_done.
- Outputs are registered. rd_data holds its last value when rd_valid=0, but is don't-care for the checker.
- Reset values: req_ready=0 during the reset cycle and 1 the cycle after; rd_valid=0, rd_last=0, wr_done=0, busy=0, rd_data=0; state IDLE; counters 0.
- Reset mid-operation: the burst is abandoned immediately and the block returns to IDLE. Bytes already written in a partial writeback remain in the store; no wr_done is issued.
- Counters wrap within OFF_W bits; the burst never crosses a line boundary.
- Address aliasing: addresses differing only above MEM_AW map to the same bytes. For example, 0x02001f81 and 0x00000f85 address the same line, base 0xf80.

Test Plan:
- Fill 0x02001f81, READ_LATENCY=4, accept at cycle 0 -> rd_valid cycles 4..19; rd_data 0x80,0x81,...,0x8f; rd_last only at cycle 19; req_ready low cycles 1..19.
- Writeback 0x02001f71 with bytes 0xA0..0xAF, no gaps -> wr_done pulses one cycle after the 16th beat. A following fill of 0x02001f7c returns 0xA0..0xAF.
- Writeback 0x02001f41 with wr_valid toggling 1,0,1,0,... -> all 16 bytes stored in order; wr_done only after the 16th valid beat.
- Reset asserted during a fill at beat 5 of 0x02001f51 -> next cycle rd_valid=0, busy=0. req_ready=1 after reset. A re-issued fill returns the full 0x50..0x5f.
- Reset mid-writeback after 3 beats (0x11,0x22,0x33) to line 0x02001f40 -> no wr_done; a later fill returns 0x11,0x22,0x33,0xA3?? no: 0x11,0x22,0x33 then the prior contents for bytes 3..15.
- req_valid held high continuously with alternating req_write -> exactly one accept per IDLE visit; wr_valid ignored during a fill; no beat lost or duplicated.
